// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared definitions for the lab datapath micro-sequencer:
//   - state_e   : sequencer FSM states
//   - KIND_*    : instruction kind codes
//   - F_*       : ALU function codes
//   - BS_*      : bus-mux select codes
//   - is_legal / is_unary : instruction decode helpers
// -----------------------------------------------------------------------------
package dp_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_A  = 4'd1,
        S_MUX_A = 4'd2,
        S_LD_A  = 4'd3,
        S_RD_B  = 4'd4,
        S_MUX_B = 4'd5,
        S_LD_B  = 4'd6,
        S_EXEC  = 4'd7,
        S_MUX_R = 4'd8,
        S_MUX_K = 4'd9,
        S_WB    = 4'd10,
        S_DONE  = 4'd11,
        S_ERR   = 4'd12
    } state_e;

    localparam logic [1:0] KIND_ALU = 2'b00;
    localparam logic [1:0] KIND_LDK = 2'b01;
    localparam logic [1:0] KIND_MOV = 2'b10;

    localparam logic [2:0] F_NOP = 3'd0;
    localparam logic [2:0] F_ADD = 3'd1;
    localparam logic [2:0] F_SUB = 3'd2;
    localparam logic [2:0] F_INC = 3'd3;
    localparam logic [2:0] F_DEC = 3'd4;
    localparam logic [2:0] F_AND = 3'd5;
    localparam logic [2:0] F_MUL = 3'd6;

    localparam logic [2:0] BS_K0  = 3'd0;
    localparam logic [2:0] BS_K1  = 3'd1;
    localparam logic [2:0] BS_K2  = 3'd2;
    localparam logic [2:0] BS_K3  = 3'd3;
    localparam logic [2:0] BS_REG = 3'd4;
    localparam logic [2:0] BS_ALU = 3'd5;

    // ALU ops need a function code in 1..6; LDK and MOV are always legal.
    function automatic logic is_legal(input logic [1:0] kind, input logic [2:0] f);
        logic ok;
        case (kind)
            KIND_ALU: ok = (f != F_NOP) && (f != 3'd7);
            KIND_LDK: ok = 1'b1;
            KIND_MOV: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unary ops only use buffer A.
    function automatic logic is_unary(input logic [2:0] f);
        return (f == F_INC) || (f == F_DEC);
    endfunction

endpackage

// File: rtl/dp_sequencer.sv
// -----------------------------------------------------------------------------
// dp_sequencer
// Micro-sequencer for the 8-bit lab datapath. Accepts one instruction per
// start pulse (ALU op, load-constant, move) and steps the datapath control
// lines so each registered stage is valid before it is consumed.
//
// Ports:
//   clock, reset_n            : clock (rising edge), async active-low reset
//   start, kind, alu_f,
//   rs, rt, rd                : instruction request, sampled only in IDLE
//   reg_add, RNW, BS,
//   WrA, WrB, ALUop           : datapath controls (all registered)
//   busy, done, err           : status (all registered)
// -----------------------------------------------------------------------------
module dp_sequencer
    import dp_pkg::*;
#(
    parameter logic [2:0] SEL_REG      = BS_REG,
    parameter logic [2:0] SEL_ALU      = BS_ALU,
    parameter bit         SKIP_B_UNARY = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] kind,
    input  logic [2:0] alu_f,
    input  logic [2:0] rs,
    input  logic [2:0] rt,
    input  logic [2:0] rd,
    output logic [2:0] reg_add,
    output logic       RNW,
    output logic [2:0] BS,
    output logic       WrA,
    output logic       WrB,
    output logic [2:0] ALUop,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e     state_q, state_d;
    logic [1:0] kind_q, kind_d;
    logic [2:0] f_q, f_d;
    logic [2:0] rs_q, rs_d;
    logic [2:0] rt_q, rt_d;
    logic [2:0] rd_q, rd_d;

    logic [2:0] reg_add_q, reg_add_d;
    logic       rnw_q, rnw_d;
    logic [2:0] bs_q, bs_d;
    logic       wra_q, wra_d;
    logic       wrb_q, wrb_d;
    logic [2:0] aluop_q, aluop_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    // Next state, instruction latch, and next-cycle output decode.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        f_d     = f_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kind_d = kind;
                    f_d    = alu_f;
                    rs_d   = rs;
                    rt_d   = rt;
                    rd_d   = rd;
                    if (!is_legal(kind, alu_f)) begin
                        state_d = S_ERR;
                    end else if (kind == KIND_LDK) begin
                        state_d = S_MUX_K;
                    end else begin
                        state_d = S_RD_A;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_A:  state_d = S_MUX_A;
            S_MUX_A: state_d = (kind_q == KIND_MOV) ? S_WB : S_LD_A;
            S_LD_A:  state_d = (SKIP_B_UNARY && is_unary(f_q)) ? S_EXEC : S_RD_B;
            S_RD_B:  state_d = S_MUX_B;
            S_MUX_B: state_d = S_LD_B;
            S_LD_B:  state_d = S_EXEC;
            S_EXEC:  state_d = S_MUX_R;
            S_MUX_R: state_d = S_WB;
            S_MUX_K: state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so that, once
        // registered, they line up with that state's cycle. BS and reg_add
        // hold unless the entered state sets them.
        reg_add_d = reg_add_q;
        rnw_d     = 1'b1;
        bs_d      = bs_q;
        wra_d     = 1'b0;
        wrb_d     = 1'b0;
        aluop_d   = 3'd0;
        busy_d    = (state_d != S_IDLE);
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_d)
            S_RD_A:  reg_add_d = rs_d;
            S_MUX_A: bs_d = SEL_REG;
            S_LD_A: begin
                bs_d  = SEL_REG;
                wra_d = 1'b1;
            end
            S_RD_B:  reg_add_d = rt_d;
            S_MUX_B: bs_d = SEL_REG;
            S_LD_B: begin
                bs_d  = SEL_REG;
                wrb_d = 1'b1;
            end
            S_EXEC:  aluop_d = f_d;
            // ALUop stays on so the ALU result register is not cleared
            // while the bus mux is capturing it.
            S_MUX_R: begin
                aluop_d = f_d;
                bs_d    = SEL_ALU;
            end
            S_MUX_K: bs_d = {1'b0, rt_d[1:0]};
            S_WB: begin
                reg_add_d = rd_d;
                rnw_d     = 1'b0;
            end
            S_DONE:  done_d = 1'b1;
            S_ERR:   err_d = 1'b1;
            default: reg_add_d = reg_add_q;
        endcase
    end

    // State, latched instruction and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            kind_q    <= 2'd0;
            f_q       <= 3'd0;
            rs_q      <= 3'd0;
            rt_q      <= 3'd0;
            rd_q      <= 3'd0;
            reg_add_q <= 3'd0;
            rnw_q     <= 1'b1;
            bs_q      <= 3'd0;
            wra_q     <= 1'b0;
            wrb_q     <= 1'b0;
            aluop_q   <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            f_q       <= f_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            reg_add_q <= reg_add_d;
            rnw_q     <= rnw_d;
            bs_q      <= bs_d;
            wra_q     <= wra_d;
            wrb_q     <= wrb_d;
            aluop_q   <= aluop_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign reg_add = reg_add_q;
    assign RNW     = rnw_q;
    assign BS      = bs_q;
    assign WrA     = wra_q;
    assign WrB     = wrb_q;
    assign ALUop   = aluop_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dp_sequencer
// Drives dp_sequencer against a behavioural model of the lab datapath
// (8x8 register file, registered bus mux with constants 0/1/2/4, ALU with
// A/B buffers and a registered result) and checks register contents,
// latency and control-line activity for each instruction.
// -----------------------------------------------------------------------------
module tb_dp_sequencer;
    import dp_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] kind;
    logic [2:0] alu_f, rs, rt, rd;
    logic [2:0] reg_add, BS, ALUop;
    logic       RNW, WrA, WrB, busy, done, err;

    int n_cmp = 0;
    int n_mis = 0;

    dp_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .kind(kind),
        .alu_f(alu_f), .rs(rs), .rt(rt), .rd(rd), .reg_add(reg_add),
        .RNW(RNW), .BS(BS), .WrA(WrA), .WrB(WrB), .ALUop(ALUop),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // ---------------- datapath model ----------------
    logic [7:0] rf [8];
    logic [7:0] bus_q = 8'd0;
    logic [7:0] a_q   = 8'd0;
    logic [7:0] b_q   = 8'd0;
    logic [7:0] ao_q  = 8'd0;
    logic       dp_clr;
    logic       poke_en;
    logic [2:0] poke_addr;
    logic [7:0] poke_val;

    function automatic logic [7:0] kconst(input logic [1:0] s);
        case (s)
            2'd0:    return 8'd0;
            2'd1:    return 8'd1;
            2'd2:    return 8'd2;
            default: return 8'd4;
        endcase
    endfunction

    function automatic logic [7:0] alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_INC:   return a + 8'd1;
            F_DEC:   return a - 8'd1;
            F_AND:   return a & b;
            F_MUL:   return p[7:0];
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (BS < 3'd4)         bus_q <= kconst(BS[1:0]);
        else if (BS == BS_REG) bus_q <= rf[reg_add];
        else if (BS == BS_ALU) bus_q <= ao_q;
        else                   bus_q <= 8'd0;
        if (WrA === 1'b1) a_q <= bus_q;
        if (WrB === 1'b1) b_q <= bus_q;
        ao_q <= (ALUop == 3'd0) ? 8'd0 : alu(ALUop, a_q, b_q);
        if (dp_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
        end else if (poke_en) begin
            rf[poke_addr] <= poke_val;
        end else if (reset_n === 1'b1 && RNW === 1'b0) begin
            rf[reg_add] <= bus_q;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         is_err;
        int         lat;
        logic [2:0] rd;
        logic [7:0] val;
        int         nwra;
        int         nwrb;
        int         nwr;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rf_pack();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = rf[i];
        return v;
    endfunction

    // Issue one instruction, watch it to completion, then compare with the
    // expectation popped from the scoreboard.
    task automatic issue(input string tag, input logic [1:0] k, input logic [2:0] f,
                         input logic [2:0] rs_i, input logic [2:0] rt_i, input logic [2:0] rd_i,
                         input int lat, input logic [7:0] val, input int nwra, input int nwrb,
                         input int nwr, input bit is_err, input int poke_at);
        exp_t        e;
        logic [63:0] snap;
        int          cwra, cwrb, cwr, lat_obs;
        logic [2:0]  waddr;
        logic        busy1, got_done, got_err;
        cwra = 0; cwrb = 0; cwr = 0; lat_obs = -1; waddr = 3'd0;
        busy1 = 1'b0; got_done = 1'b0; got_err = 1'b0;
        snap = rf_pack();
        sb.push_back('{is_err, lat, rd_i, val, nwra, nwrb, nwr});
        @(negedge clock);
        kind = k; alu_f = f; rs = rs_i; rt = rt_i; rd = rd_i; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) busy1 = busy;
            if (WrA === 1'b1) cwra++;
            if (WrB === 1'b1) cwrb++;
            if (RNW === 1'b0) begin
                cwr++;
                waddr = reg_add;
            end
            if (c == poke_at) begin
                start = 1'b1; kind = KIND_LDK; rt = 3'd3; rd = 3'd7;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1 || err === 1'b1) begin
                lat_obs = c; got_done = done; got_err = err;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
        e = sb.pop_front();
        if (lat_obs < 0) chk({tag, " timeout"}, 32'd0, 32'd1);
        chk({tag, " busy_after_accept"}, {31'd0, busy1}, 32'd1);
        chk({tag, " latency"}, lat_obs, e.lat);
        chk({tag, " done"}, {31'd0, got_done}, {31'd0, !e.is_err});
        chk({tag, " err"}, {31'd0, got_err}, {31'd0, e.is_err});
        chk({tag, " WrA_cycles"}, cwra, e.nwra);
        chk({tag, " WrB_cycles"}, cwrb, e.nwrb);
        chk({tag, " write_cycles"}, cwr, e.nwr);
        if (e.is_err) begin
            chk({tag, " regfile_unchanged"}, {31'd0, rf_pack() === snap}, 32'd1);
        end else begin
            chk({tag, " write_addr"}, {29'd0, waddr}, {29'd0, e.rd});
            chk({tag, " R[rd]"}, {24'd0, rf[e.rd]}, {24'd0, e.val});
        end
        @(negedge clock);
        chk({tag, " pulse_end"}, {30'd0, done, err}, 32'd0);
        chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic poke(input logic [2:0] addr, input logic [7:0] val);
        @(negedge clock);
        poke_addr = addr; poke_val = val; poke_en = 1'b1;
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rnw_low, done_seen;
        reset_n = 1'b0; dp_clr = 1'b1; start = 1'b0; kind = 2'd0; alu_f = 3'd0;
        rs = 3'd0; rt = 3'd0; rd = 3'd0; poke_en = 1'b0; poke_addr = 3'd0; poke_val = 8'd0;
        repeat (3) @(negedge clock);
        chk("reset reg_add", {29'd0, reg_add}, 32'd0);
        chk("reset RNW", {31'd0, RNW}, 32'd1);
        chk("reset BS", {29'd0, BS}, 32'd0);
        chk("reset WrA_WrB", {30'd0, WrA, WrB}, 32'd0);
        chk("reset ALUop", {29'd0, ALUop}, 32'd0);
        chk("reset busy_done_err", {29'd0, busy, done, err}, 32'd0);
        reset_n = 1'b1; dp_clr = 1'b0;
        @(negedge clock);
        chk("post-reset busy", {31'd0, busy}, 32'd0);

        //    tag        kind      f      rs    rt    rd    lat val     A B W err poke
        issue("ldk1",  KIND_LDK, 3'd0, 3'd0, 3'd3, 3'd1, 3,  8'd4,   0,0,1,0,0);
        issue("ldk2",  KIND_LDK, 3'd0, 3'd0, 3'd2, 3'd2, 3,  8'd2,   0,0,1,0,0);
        issue("add",   KIND_ALU, F_ADD,3'd1, 3'd2, 3'd3, 10, 8'd6,   1,1,1,0,0);
        issue("sub",   KIND_ALU, F_SUB,3'd1, 3'd2, 3'd5, 10, 8'd2,   1,1,1,0,0);
        poke(3'd1, 8'd200);
        issue("mul",   KIND_ALU, F_MUL,3'd1, 3'd2, 3'd5, 10, 8'd144, 1,1,1,0,0);
        issue("inc",   KIND_ALU, F_INC,3'd3, 3'd0, 3'd4, 7,  8'd7,   1,0,1,0,0);
        issue("mov",   KIND_MOV, 3'd0, 3'd4, 3'd0, 3'd0, 4,  8'd7,   0,0,1,0,0);
        issue("ill_f0",KIND_ALU, 3'd0, 3'd1, 3'd2, 3'd6, 1,  8'd0,   0,0,0,1,0);
        issue("ill_f7",KIND_ALU, 3'd7, 3'd1, 3'd2, 3'd6, 1,  8'd0,   0,0,0,1,0);
        issue("ill_k3",2'b11,    F_ADD,3'd1, 3'd2, 3'd6, 1,  8'd0,   0,0,0,1,0);
        issue("busy_start", KIND_ALU, F_ADD, 3'd3, 3'd4, 3'd6, 10, 8'd13, 1,1,1,0,5);
        repeat (4) @(negedge clock);
        chk("dropped start busy", {31'd0, busy}, 32'd0);
        chk("dropped start R7", {24'd0, rf[7]}, 32'd0);

        // Reset while in EXEC must abandon the instruction with no write.
        kind = KIND_ALU; alu_f = F_ADD; rs = 3'd1; rt = 3'd2; rd = 3'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk("pre-reset ALUop in EXEC", {29'd0, ALUop}, {29'd0, F_ADD});
        reset_n = 1'b0;
        #1;
        chk("mid-reset outputs", {reg_add, RNW, BS, WrA, WrB, ALUop, busy, done, err},
            {3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
        rnw_low = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (RNW !== 1'b1) rnw_low++;
        end
        chk("RNW held during reset", rnw_low, 0);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (RNW !== 1'b1) rnw_low++;
            if (done === 1'b1) done_seen++;
        end
        chk("after reset no write", rnw_low, 0);
        chk("after reset no done", done_seen, 0);
        chk("after reset busy", {31'd0, busy}, 32'd0);
        chk("aborted R7", {24'd0, rf[7]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Micro-sequencer for the 8-bit lab datapath (8x8 register file, registered bus mux, ALU with A/B buffers).
- Accepts one instruction per start pulse: ALU op, load-constant, or move.
- Drives reg_add/RNW/BS/WrA/WrB/ALUop cycle by cycle so that each registered datapath stage is valid before it is used.
- Sits between a top-level command source (switches/test bench) and the datapath; the datapath is unchanged.

Parameters:
- SEL_REG, 4, BS code selecting register-file output onto the bus.
- SEL_ALU, 5, BS code selecting ALU output onto the bus.
- SKIP_B_UNARY, 1, when 1 the unary ops (A+1, A-1) skip the B-load states.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- kind  in  2  00 ALU, 01 LDK (load constant), 10 MOV, 11 illegal.
- alu_f  in  3  ALU function; legal values 1..6.
- rs  in  3  source A register; unused by LDK.
- rt  in  3  source B register for ALU; rt[1:0] is the constant select (BS 0..3) for LDK.
- rd  in  3  destination register.
- reg_add  out  3  register-file address.
- RNW  out  1  1 = read, 0 = write.
- BS  out  3  mux select.
- WrA  out  1  load ALU buffer A.
- WrB  out  1  load ALU buffer B.
- ALUop  out  3  ALU function.
- busy  out  1  high from the cycle after start acceptance until DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse on an illegal instruction.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, reg_add=0, RNW=1, BS=0, WrA=0, WrB=0, ALUop=0, busy=0, done=0, err=0.
- No register write may occur while reset_n=0.
- Reset mid-instruction abandons the instruction. No write follows, even from WB.
- Instruction fields are latched on the accepting edge (IDLE with start=1). Inputs are ignored otherwise; start while busy is dropped.
- Illegal instruction: kind=11, or kind=00 with alu_f 0 or 7. The FSM goes to ERR for 1 cycle (err=1), then IDLE. No datapath writes occur.
- Outputs are Moore, decoded from the state register and the latched fields. No combinational path exists from inputs to outputs.
- Default in every state: RNW=1, WrA=0, WrB=0, ALUop=0. BS holds its last value unless the state lists it.
- States (one cycle each) and their outputs:
  - RD_A: reg_add=rs.
  - MUX_A: BS=SEL_REG.
  - LD_A: BS=SEL_REG, WrA=1.
  - RD_B: reg_add=rt.
  - MUX_B: BS=SEL_REG.
  - LD_B: BS=SEL_REG, WrB=1.
  - EXEC: ALUop=f.
  - MUX_R: ALUop=f held, so AO is not cleared while the mux samples; BS=SEL_ALU.
  - MUX_K: BS={1'b0,rt[1:0]}.
  - WB: reg_add=rd, RNW=0, BS held.
  - DONE: done=1.
- Sequences and latency (cycles from the accepting edge to the DONE cycle):
  - ALU binary: RD_A, MUX_A, LD_A, RD_B, MUX_B, LD_B, EXEC, MUX_R, WB, DONE = 10.
  - ALU unary (f=3,4 with SKIP_B_UNARY=1): RD_A, MUX_A, LD_A, EXEC, MUX_R, WB, DONE = 7.
  - MOV: RD_A, MUX_A, WB, DONE = 4.
  - LDK: MUX_K, WB, DONE = 3.
- DONE returns to IDLE. A new start is accepted in the IDLE cycle that follows, so there is no back-to-back acceptance in DONE.
- Arithmetic is performed by the ALU (8-bit, wraps mod 256). The sequencer never touches data.

Decomposition:
- Shared package dp_pkg holds:
  - state enum;
  - kind codes (KIND_ALU, KIND_LDK, KIND_MOV);
  - ALU function codes (F_NOP..F_MUL);
  - BS codes (BS_K0..BS_K3, BS_REG, BS_ALU).
- Single module; no sub-module is warranted.
- Integration test harness instantiates dp_sequencer with the existing register, mux and ALU blocks.

Test Plan:
- Reset: reset_n=0 mid-sequence → all outputs at reset values next sample, RNW=1 throughout. After release, IDLE with busy=0.
- LDK rt=3 rd=1, then LDK rt=2 rd=2 → R1=4, R2=2. done 3 cycles after each start. Exactly one RNW=0 cycle each, with reg_add=rd.
- ALU f=1 rs=1 rt=2 rd=3 → R3=6, done at cycle 10, WrA and WrB each high exactly 1 cycle. Repeat f=2 rs=1 rt=2 rd=5 → R5=2; f=6 with R1=200, R2=2 → R5=144 (wrap).
- ALU f=3 rs=3 rd=4 → R4=7, done at cycle 7, WrB never asserted. MOV rs=4 rd=0 → R0=7 at cycle 4.
- Illegal: kind=00 f=0; kind=00 f=7; kind=11 → err pulse 1 cycle, register file unchanged, no WrA/WrB.
- start pulsed again during busy (cycle 5 of an ALU op) → ignored. Reset asserted in EXEC → R[rd] unchanged.
